// File: rtl/psa_search_scheduler.sv
// psa_search_scheduler: shares one PSA pattern-search engine between NREQ
// requesters. Round-robin grant, job validation, engine reset/activate
// sequencing with a done guard window and a run timeout, and result return.
module psa_search_scheduler #(
  parameter int              NREQ       = 2,
  parameter int              TMO_W      = 27,
  parameter logic [TMO_W-1:0] TMO_CYCLES = 27'h3FFFFFF
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*8-1:0]  req_p,
  input  logic [NREQ*8-1:0]  req_pl,
  input  logic [NREQ*15-1:0] req_b,
  input  logic [NREQ*15-1:0] req_bl,
  output logic [NREQ-1:0]    req_ack,
  output logic [NREQ-1:0]    resp_valid,
  output logic [14:0]        resp_found,
  output logic               resp_err,
  output logic               busy,
  output logic [7:0]         eng_p,
  output logic [7:0]         eng_pl,
  output logic [14:0]        eng_b,
  output logic [14:0]        eng_bl,
  output logic               eng_reset,
  output logic               eng_activate,
  input  logic               eng_done,
  input  logic [14:0]        eng_found
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [14:0] ERR_FOUND = 15'h7FFF;

  // Requester fields unpacked into fixed 4-entry tables so a 2-bit index
  // always fits; entries beyond NREQ read as idle/zero.
  logic        req_v  [4];
  logic [7:0]  p_arr  [4];
  logic [7:0]  pl_arr [4];
  logic [14:0] b_arr  [4];
  logic [14:0] bl_arr [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_req
      if (gi < NREQ) begin : g_used
        assign req_v[gi]  = req[gi];
        assign p_arr[gi]  = req_p[8*gi +: 8];
        assign pl_arr[gi] = req_pl[8*gi +: 8];
        assign b_arr[gi]  = req_b[15*gi +: 15];
        assign bl_arr[gi] = req_bl[15*gi +: 15];
      end else begin : g_unused
        assign req_v[gi]  = 1'b0;
        assign p_arr[gi]  = '0;
        assign pl_arr[gi] = '0;
        assign b_arr[gi]  = '0;
        assign bl_arr[gi] = '0;
      end
    end
  endgenerate

  logic [1:0]       state_reg, state_next;
  logic [1:0]       rr_reg;        // last winner, also owner of the running job
  logic [TMO_W-1:0] cnt_reg;
  logic [NREQ-1:0]  req_ack_reg, resp_valid_reg;
  logic [14:0]      resp_found_reg;
  logic             resp_err_reg, busy_reg;
  logic [7:0]       eng_p_reg, eng_pl_reg;
  logic [14:0]      eng_b_reg, eng_bl_reg;
  logic             eng_reset_reg, eng_activate_reg;

  logic             grant_found;
  logic [1:0]       grant_idx;
  logic [15:0]      blk_end;
  logic             job_ok;
  logic             done_ok;
  logic             tmo_hit;

  // Round-robin scan starting one past the previous winner.
  always_comb begin
    int cidx;
    grant_found = 1'b0;
    grant_idx   = rr_reg;
    cidx        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cidx = (int'(rr_reg) + k) % NREQ;
      if (!grant_found && req_v[cidx]) begin
        grant_found = 1'b1;
        grant_idx   = 2'(cidx);
      end
    end
  end

  // A job must have a non-empty pattern no longer than a non-empty block
  // that stays inside the 32K address space.
  assign blk_end = {1'b0, b_arr[grant_idx]} + {1'b0, bl_arr[grant_idx]};
  assign job_ok  = (pl_arr[grant_idx] != 8'd0) && (bl_arr[grant_idx] != 15'd0) &&
                   ({7'd0, pl_arr[grant_idx]} <= bl_arr[grant_idx]) &&
                   (blk_end <= 16'd32768);

  // done is distrusted for the first two RUN cycles: it may still be the
  // previous job's flag while the engine comes out of reset.
  assign done_ok = eng_done && (cnt_reg >= TMO_W'(2));
  assign tmo_hit = (cnt_reg == TMO_CYCLES - TMO_W'(1));

  // Next-state selection.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (grant_found) state_next = job_ok ? ST_LOAD : ST_RESP;
      ST_LOAD: state_next = ST_RUN;
      ST_RUN:  if (done_ok || tmo_hit) state_next = ST_RESP;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, job latch, timeout counter and all registered outputs.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      rr_reg           <= 2'(NREQ - 1);
      cnt_reg          <= '0;
      req_ack_reg      <= '0;
      resp_valid_reg   <= '0;
      resp_found_reg   <= '0;
      resp_err_reg     <= 1'b0;
      busy_reg         <= 1'b0;
      eng_p_reg        <= '0;
      eng_pl_reg       <= '0;
      eng_b_reg        <= '0;
      eng_bl_reg       <= '0;
      eng_reset_reg    <= 1'b1;
      eng_activate_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      busy_reg         <= (state_next != ST_IDLE);
      eng_reset_reg    <= (state_next == ST_LOAD);
      eng_activate_reg <= (state_next == ST_RUN);
      req_ack_reg      <= '0;
      resp_valid_reg   <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_found) begin
            rr_reg      <= grant_idx;
            req_ack_reg <= NREQ'(1) << grant_idx;
            eng_p_reg   <= p_arr[grant_idx];
            eng_pl_reg  <= pl_arr[grant_idx];
            eng_b_reg   <= b_arr[grant_idx];
            eng_bl_reg  <= bl_arr[grant_idx];
            if (!job_ok) begin
              resp_err_reg   <= 1'b1;
              resp_found_reg <= ERR_FOUND;
            end
          end
        end
        ST_LOAD: cnt_reg <= '0;
        ST_RUN: begin
          cnt_reg <= cnt_reg + TMO_W'(1);
          if (done_ok) begin
            resp_err_reg   <= 1'b0;
            resp_found_reg <= eng_found;
          end else if (tmo_hit) begin
            resp_err_reg   <= 1'b1;
            resp_found_reg <= ERR_FOUND;
          end
        end
        default: resp_valid_reg <= NREQ'(1) << rr_reg;
      endcase
    end
  end

  assign req_ack      = req_ack_reg;
  assign resp_valid   = resp_valid_reg;
  assign resp_found   = resp_found_reg;
  assign resp_err     = resp_err_reg;
  assign busy         = busy_reg;
  assign eng_p        = eng_p_reg;
  assign eng_pl       = eng_pl_reg;
  assign eng_b        = eng_b_reg;
  assign eng_bl       = eng_bl_reg;
  assign eng_reset    = eng_reset_reg;
  assign eng_activate = eng_activate_reg;

endmodule

// File: tb/tb_psa_search_scheduler.sv
// Bench for psa_search_scheduler: table of single jobs plus hand-written
// sequences for reset, arbitration rotation, stale done and mid-run reset.
module tb_psa_search_scheduler;
  localparam int NREQ = 2;

  logic               CLK100MHZ = 1'b0;
  logic               reset = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*8-1:0]  req_p = '0;
  logic [NREQ*8-1:0]  req_pl = '0;
  logic [NREQ*15-1:0] req_b = '0;
  logic [NREQ*15-1:0] req_bl = '0;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    resp_valid;
  logic [14:0]        resp_found;
  logic               resp_err;
  logic               busy;
  logic [7:0]         eng_p;
  logic [7:0]         eng_pl;
  logic [14:0]        eng_b;
  logic [14:0]        eng_bl;
  logic               eng_reset;
  logic               eng_activate;
  logic               eng_done = 1'b0;
  logic [14:0]        eng_found = '0;

  int          eng_lat = 0;
  logic [14:0] eng_found_val = '0;
  bit          stale_mode = 1'b0;
  int          run_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  typedef struct {
    int          id;
    logic [7:0]  p;
    logic [7:0]  pl;
    logic [14:0] b;
    logic [14:0] bl;
    bit          inval;
    int          lat;
    logic [14:0] found;
    logic        exp_err;
    logic [14:0] exp_found;
  } vec_t;

  vec_t vecs[8];
  vec_t post_vec;

  psa_search_scheduler #(.NREQ(NREQ), .TMO_W(27), .TMO_CYCLES(27'd100)) dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .req(req), .req_p(req_p),
    .req_pl(req_pl), .req_b(req_b), .req_bl(req_bl), .req_ack(req_ack),
    .resp_valid(resp_valid), .resp_found(resp_found), .resp_err(resp_err),
    .busy(busy), .eng_p(eng_p), .eng_pl(eng_pl), .eng_b(eng_b),
    .eng_bl(eng_bl), .eng_reset(eng_reset), .eng_activate(eng_activate),
    .eng_done(eng_done), .eng_found(eng_found)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // Engine model: done rises after eng_lat activate cycles and holds until
  // reset. In stale mode the old done survives reset, drops in the third
  // RUN cycle and never rises again.
  always @(negedge CLK100MHZ) begin
    if (eng_reset) begin
      run_cnt = 0;
      if (!stale_mode) eng_done = 1'b0;
    end else if (eng_activate) begin
      run_cnt = run_cnt + 1;
      if (stale_mode) begin
        if (run_cnt == 3) eng_done = 1'b0;
      end else if (!eng_done && run_cnt == eng_lat) begin
        eng_done  = 1'b1;
        eng_found = eng_found_val;
      end
    end
  end

  task automatic tick;
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_fields(input int id, input logic [7:0] p, input logic [7:0] pl,
                            input logic [14:0] b, input logic [14:0] bl);
    req_p[8*id +: 8]   = p;
    req_pl[8*id +: 8]  = pl;
    req_b[15*id +: 15] = b;
    req_bl[15*id +: 15] = bl;
  endtask

  // One isolated job from a single requester, checked end to end.
  task automatic apply_vec(input vec_t v);
    logic [NREQ-1:0] oh;
    int runs;
    oh = NREQ'(1) << v.id;
    set_fields(v.id, v.p, v.pl, v.b, v.bl);
    eng_lat = v.lat;
    eng_found_val = v.found;
    req = oh;
    tick;
    chk("ack", 32'(req_ack), 32'(oh));
    chk("eng_p", 32'(eng_p), 32'(v.p));
    chk("eng_pl", 32'(eng_pl), 32'(v.pl));
    chk("eng_b", 32'(eng_b), 32'(v.b));
    chk("eng_bl", 32'(eng_bl), 32'(v.bl));
    chk("busy_granted", 32'(busy), 32'd1);
    req = '0;
    runs = 0;
    if (v.inval) begin
      chk("inval_no_engine", 32'({eng_reset, eng_activate}), 32'd0);
      tick;
    end else begin
      chk("load_eng_reset", 32'(eng_reset), 32'd1);
      chk("load_no_activate", 32'(eng_activate), 32'd0);
      for (int c = 0; c < 300 && resp_valid == '0; c++) begin
        tick;
        if (eng_activate) runs++;
      end
      chk("run_cycles", 32'(runs), 32'(v.lat));
    end
    chk("resp_valid", 32'(resp_valid), 32'(oh));
    chk("resp_err", 32'(resp_err), 32'(v.exp_err));
    chk("resp_found", 32'(resp_found), 32'(v.exp_found));
    chk("resp_activate_low", 32'(eng_activate), 32'd0);
    chk("resp_idle", 32'(busy), 32'd0);
    $display("job req=%0d pl=%0d b=%0d bl=%0d -> err=%0b found=%h run=%0d",
             v.id, v.pl, v.b, v.bl, resp_err, resp_found, runs);
    tick;
    chk("resp_one_pulse", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[$];
    int nresp, runs, last_ack;
    bit pending, no_resp;

    //        id p  pl  b       bl       inval lat  found    err   exp_found
    vecs[0] = '{0, 0, 3,  0,      250,     0,    40,  15'd17,  1'b0, 15'd17};
    vecs[1] = '{1, 5, 8,  100,    8,       0,    12,  15'h0FF, 1'b0, 15'h0FF};
    vecs[2] = '{0, 1, 0,  0,      10,      1,    0,   15'd0,   1'b1, 15'h7FFF};
    vecs[3] = '{1, 2, 9,  0,      4,       1,    0,   15'd0,   1'b1, 15'h7FFF};
    vecs[4] = '{0, 3, 2,  32760,  10,      1,    0,   15'd0,   1'b1, 15'h7FFF};
    vecs[5] = '{1, 4, 2,  32758,  10,      0,    7,   15'd1234,1'b0, 15'd1234};
    vecs[6] = '{0, 6, 1,  7,      0,       1,    0,   15'd0,   1'b1, 15'h7FFF};
    vecs[7] = '{1, 7, 4,  20,     30,      0,    100, 15'd99,  1'b0, 15'd99};
    post_vec = '{1, 9, 5, 300,    40,      0,    6,   15'd77,  1'b0, 15'd77};

    // Reset held three cycles.
    tick;
    chk("rst_eng_reset", 32'(eng_reset), 32'd1);
    tick;
    tick;
    chk("rst_outputs", 32'({req_ack, resp_valid, resp_err, busy, eng_activate}), 32'd0);
    chk("rst_found", 32'(resp_found), 32'd0);
    chk("rst_eng_fields", 32'(eng_p | eng_pl | eng_b | eng_bl), 32'd0);
    chk("rst_eng_reset_held", 32'(eng_reset), 32'd1);
    reset = 1'b0;
    tick;
    chk("idle_eng_reset", 32'(eng_reset), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Both requesters held: grants must rotate 0,1,0,1 with one response each.
    set_fields(0, 8'd1, 8'd2, 15'd0, 15'd20);
    set_fields(1, 8'd2, 8'd3, 15'd50, 15'd20);
    eng_lat = 5;
    eng_found_val = 15'd42;
    req = 2'b11;
    nresp = 0;
    pending = 1'b0;
    last_ack = -1;
    for (int c = 0; c < 400 && nresp < 4; c++) begin
      tick;
      if (req_ack != '0) begin
        chk("rot_ack_while_pending", 32'(pending), 32'd0);
        last_ack = (req_ack == 2'b10) ? 1 : 0;
        grants.push_back(last_ack);
        pending = 1'b1;
      end
      if (resp_valid != '0) begin
        chk("rot_resp_pending", 32'(pending), 32'd1);
        chk("rot_resp_id", 32'(resp_valid), 32'(2'b01 << last_ack));
        chk("rot_resp_found", 32'(resp_found), 32'd42);
        $display("rotation resp req=%0d found=%h", last_ack, resp_found);
        pending = 1'b0;
        nresp++;
        if (nresp == 4) req = '0;
      end
    end
    chk("rot_resp_count", 32'(nresp), 32'd4);
    chk("rot_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size(); i++) chk("rot_order", 32'(grants[i]), 32'(i % 2));
    tick;
    tick;

    // Directed job table.
    for (int i = 0; i < 8; i++) begin
      apply_vec(vecs[i]);
      tick;
    end

    // Stale done from the previous job must be ignored; job then times out.
    stale_mode = 1'b1;
    set_fields(0, 8'd1, 8'd2, 15'd0, 15'd50);
    req = 2'b01;
    tick;
    chk("stale_ack", 32'(req_ack), 32'd1);
    req = '0;
    runs = 0;
    for (int c = 0; c < 300 && resp_valid == '0; c++) begin
      tick;
      if (eng_activate) runs++;
    end
    chk("tmo_run_cycles", 32'(runs), 32'd100);
    chk("tmo_resp_valid", 32'(resp_valid), 32'd1);
    chk("tmo_resp_err", 32'(resp_err), 32'd1);
    chk("tmo_resp_found", 32'(resp_found), 32'h7FFF);
    $display("timeout job req=0 -> err=%0b found=%h run=%0d", resp_err, resp_found, runs);
    stale_mode = 1'b0;
    tick;
    tick;

    // Reset in the 10th RUN cycle abandons the job silently.
    set_fields(1, 8'd3, 8'd4, 15'd10, 15'd60);
    eng_lat = 50;
    eng_found_val = 15'd5;
    req = 2'b10;
    tick;
    chk("abort_ack", 32'(req_ack), 32'b10);
    req = '0;
    runs = 0;
    for (int c = 0; c < 50 && runs < 10; c++) begin
      tick;
      if (eng_activate) runs++;
    end
    chk("abort_reached_run10", 32'(runs), 32'd10);
    reset = 1'b1;
    tick;
    chk("abort_activate", 32'(eng_activate), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_eng_reset", 32'(eng_reset), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    no_resp = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      if (resp_valid != '0 || busy) no_resp = 1'b0;
    end
    chk("abort_no_response", 32'(no_resp), 32'd1);
    $display("abort job req=1 at run cycle %0d, no response", runs);
    apply_vec(post_vec);

    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
